// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for the 8N1 UART receiver.
// The master side drives the serial line and the oversampling tick; the slave side is the receiver.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 sample_tick;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;

  modport master (
    output rx,
    output sample_tick,
    input  data_out,
    input  rx_valid,
    input  rx_busy,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  sample_tick,
    output data_out,
    output rx_valid,
    output rx_busy,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: synchronises rx, centre-samples each bit on sample_tick,
// and reports each good byte with a one-clk valid pulse. A low stop bit raises a one-clk framing error.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 ferr_q;
  logic                 rx_meta;
  logic                 rxs;

  // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= (state != IDLE);

      case (state)
        // Start-edge detection runs every clk so the start bit is caught with minimum skew.
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        // A line that is high again at mid start bit was a glitch, not a frame.
        START: begin
          if (bus.sample_tick) begin
            if (tick_cnt == MID_START) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (bus.sample_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt  <= '0;
              shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        // Leaving mid stop bit lets a back-to-back start edge be seen with no idle gap.
        STOP: begin
          if (bus.sample_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (rxs) begin
                data_q  <= shift_reg;
                valid_q <= 1'b1;
                state   <= IDLE;
              end else begin
                ferr_q <= 1'b1;
                state  <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        // Wait out a held-low line so it is not decoded as a stream of 0x00 frames.
        BREAK: begin
          if (bus.sample_tick && rxs) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = ferr_q;

  valid_ferr_exclusive: assert property (@(posedge clk) disable iff (!rst) !(valid_q && ferr_q));

endmodule
